// File: rtl/bcd_modn_counter.sv
// Multi-digit BCD modulo-N up/down counter with built-in prescaler, synchronous load and wrap pulse.
// bcd/step/tc update on the prescaler-wrap edge (0 cycles); load overrides a coincident step; no backpressure.
module bcd_modn_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int MODULUS    = 60,
    parameter int PRESCALE   = 50_000_000,
    parameter int PS_W       = 26
) (
    input  logic                    Clk_50M,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    step,
    output logic                    tc,
    output logic                    load_err
);

    localparam int W = 4 * NUM_DIGITS;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam longint       DIGIT_RANGE = pow10(NUM_DIGITS);
    localparam logic [W-1:0] MAX_BCD     = int_to_bcd(MODULUS - 1);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 6 || MODULUS < 2 ||
            longint'(MODULUS) > DIGIT_RANGE || PRESCALE < 1 || PS_W < 1 ||
            (PS_W < 32 && (longint'(1) << PS_W) < longint'(PRESCALE))) begin : g_bad_params
            $error("bcd_modn_counter: illegal parameter combination");
        end
    endgenerate

    logic [PS_W-1:0] ps;
    logic [W-1:0]    bcd_inc;
    logic [W-1:0]    bcd_dec;
    logic            carry;
    logic            borrow;
    logic            digits_ok;
    logic            load_ok;
    logic            at_max;
    logic            at_zero;
    logic            ps_wrap;

    // Ripple carry/borrow across digits; wrap at the modulus is handled separately.
    always_comb begin
        bcd_inc = bcd;
        bcd_dec = bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // With every digit in 0..9, packed BCD orders the same as its numeric value.
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    assign load_ok = digits_ok && (load_bcd <= MAX_BCD);
    assign at_max  = (bcd == MAX_BCD);
    assign at_zero = (bcd == '0);
    assign ps_wrap = (ps == PS_LAST);

    always_ff @(posedge Clk_50M) begin
        if (RST) begin
            bcd      <= '0;
            ps       <= '0;
            step     <= 1'b0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            step     <= 1'b0;
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                ps <= '0;
                if (load_ok) begin
                    bcd <= load_bcd;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (ps_wrap) begin
                    ps   <= '0;
                    step <= 1'b1;
                    if (dir) begin
                        if (at_max) begin
                            bcd <= '0;
                            tc  <= 1'b1;
                        end else begin
                            bcd <= bcd_inc;
                        end
                    end else begin
                        if (at_zero) begin
                            bcd <= MAX_BCD;
                            tc  <= 1'b1;
                        end else begin
                            bcd <= bcd_dec;
                        end
                    end
                end else begin
                    ps <= ps + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: three configurations checked every cycle against an integer reference model.
module tb_bcd_modn_counter;

    logic        clk = 1'b0;
    logic [2:0]  rst_i;
    logic [2:0]  en_i;
    logic [2:0]  dir_i;
    logic [2:0]  ld_i;
    logic [23:0] ldv_i [3];
    logic [7:0]  bcd0;
    logic [7:0]  bcd1;
    logic [11:0] bcd2;
    logic [2:0]  stp;
    logic [2:0]  tcs;
    logic [2:0]  lerr;

    int n_chk  = 0;
    int n_fail = 0;

    int mods [3] = '{60, 24, 1000};
    int pres [3] = '{3, 1, 1};
    int nds  [3] = '{2, 2, 3};

    int mv   [3];
    int mps  [3];
    bit mstep[3];
    bit mtc  [3];
    bit merr [3];

    always #5 clk = ~clk;

    bcd_modn_counter #(.NUM_DIGITS(2), .MODULUS(60), .PRESCALE(3), .PS_W(2)) dut0 (
        .Clk_50M(clk), .RST(rst_i[0]), .en(en_i[0]), .dir(dir_i[0]), .load(ld_i[0]),
        .load_bcd(ldv_i[0][7:0]), .bcd(bcd0), .step(stp[0]), .tc(tcs[0]), .load_err(lerr[0]));

    bcd_modn_counter #(.NUM_DIGITS(2), .MODULUS(24), .PRESCALE(1), .PS_W(1)) dut1 (
        .Clk_50M(clk), .RST(rst_i[1]), .en(en_i[1]), .dir(dir_i[1]), .load(ld_i[1]),
        .load_bcd(ldv_i[1][7:0]), .bcd(bcd1), .step(stp[1]), .tc(tcs[1]), .load_err(lerr[1]));

    bcd_modn_counter #(.NUM_DIGITS(3), .MODULUS(1000), .PRESCALE(1), .PS_W(1)) dut2 (
        .Clk_50M(clk), .RST(rst_i[2]), .en(en_i[2]), .dir(dir_i[2]), .load(ld_i[2]),
        .load_bcd(ldv_i[2][11:0]), .bcd(bcd2), .step(stp[2]), .tc(tcs[2]), .load_err(lerr[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int value);
        logic [23:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] b, input int nd);
        for (int i = 0; i < nd; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_val(input logic [23:0] b, input int nd);
        int s = 0;
        int w = 1;
        for (int i = 0; i < nd; i++) begin
            s = s + int'(b[4*i +: 4]) * w;
            w = w * 10;
        end
        return s;
    endfunction

    function automatic logic [31:0] dut_bcd(input int k);
        case (k)
            0:       return {24'd0, bcd0};
            1:       return {24'd0, bcd1};
            default: return {20'd0, bcd2};
        endcase
    endfunction

    // Reference: count kept as a plain integer, wraps by modular arithmetic.
    task automatic model_update(input int k);
        mstep[k] = 1'b0;
        mtc[k]   = 1'b0;
        merr[k]  = 1'b0;
        if (rst_i[k]) begin
            mv[k]  = 0;
            mps[k] = 0;
        end else if (ld_i[k]) begin
            mps[k] = 0;
            if (bcd_ok(ldv_i[k], nds[k]) && bcd_val(ldv_i[k], nds[k]) < mods[k])
                mv[k] = bcd_val(ldv_i[k], nds[k]);
            else
                merr[k] = 1'b1;
        end else if (en_i[k]) begin
            if (mps[k] == pres[k] - 1) begin
                mps[k]   = 0;
                mstep[k] = 1'b1;
                if (dir_i[k]) begin
                    mtc[k] = (mv[k] == mods[k] - 1);
                    mv[k]  = (mv[k] + 1) % mods[k];
                end else begin
                    mtc[k] = (mv[k] == 0);
                    mv[k]  = (mv[k] + mods[k] - 1) % mods[k];
                end
            end else begin
                mps[k]++;
            end
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_update(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("bcd%0d", k), dut_bcd(k), {8'd0, to_bcd(mv[k])});
            check_val($sformatf("step%0d", k), {31'd0, stp[k]}, {31'd0, mstep[k]});
            check_val($sformatf("tc%0d", k), {31'd0, tcs[k]}, {31'd0, mtc[k]});
            check_val($sformatf("load_err%0d", k), {31'd0, lerr[k]}, {31'd0, merr[k]});
        end
    endtask

    task automatic set_in(input int k, input bit r, input bit e, input bit d, input bit l,
                          input logic [23:0] v);
        rst_i[k] = r;
        en_i[k]  = e;
        dir_i[k] = d;
        ld_i[k]  = l;
        ldv_i[k] = v;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) set_in(k, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        tick();
        check_val("reset_bcd0", {24'd0, bcd0}, 32'h00);
        check_val("reset_step0", {31'd0, stp[0]}, 32'd0);

        // Count up from reset: first step on the third edge, wrap 59->00 at step 60.
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
        tick();
        tick();
        check_val("t1_no_early_step", {31'd0, stp[0]}, 32'd0);
        tick();
        check_val("t1_first_step", {31'd0, stp[0]}, 32'd1);
        check_val("t1_bcd01", {24'd0, bcd0}, 32'h01);
        repeat (176) tick();
        check_val("t1_bcd59", {24'd0, bcd0}, 32'h59);
        tick();
        check_val("t1_wrap00", {24'd0, bcd0}, 32'h00);
        check_val("t1_wrap_tc", {31'd0, tcs[0]}, 32'd1);
        tick();
        check_val("t1_tc_single", {31'd0, tcs[0]}, 32'd0);

        // Count down through zero.
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00);
        tick();
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00);
        repeat (3) tick();
        check_val("t2_bcd59", {24'd0, bcd0}, 32'h59);
        check_val("t2_tc", {31'd0, tcs[0]}, 32'd1);
        repeat (27) tick();
        check_val("t2_bcd50", {24'd0, bcd0}, 32'h50);
        repeat (3) tick();
        check_val("t2_bcd49", {24'd0, bcd0}, 32'h49);

        // Load acceptance and rejection.
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h42);
        tick();
        check_val("t3_load42", {24'd0, bcd0}, 32'h42);
        check_val("t3_err_42", {31'd0, lerr[0]}, 32'd0);
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h60);
        tick();
        check_val("t3_keep_60", {24'd0, bcd0}, 32'h42);
        check_val("t3_err_60", {31'd0, lerr[0]}, 32'd1);
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h3A);
        tick();
        check_val("t3_keep_3A", {24'd0, bcd0}, 32'h42);
        check_val("t3_err_3A", {31'd0, lerr[0]}, 32'd1);

        // Load in the cycle the prescaler would wrap.
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        for (int i = 0; i < 3 && mps[0] != 2; i++) tick();
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h15);
        tick();
        check_val("t4_load15", {24'd0, bcd0}, 32'h15);
        check_val("t4_no_step", {31'd0, stp[0]}, 32'd0);
        check_val("t4_no_tc", {31'd0, tcs[0]}, 32'd0);
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        tick();
        tick();
        check_val("t4_step_late", {31'd0, stp[0]}, 32'd0);
        tick();
        check_val("t4_step_3rd", {31'd0, stp[0]}, 32'd1);
        check_val("t4_bcd16", {24'd0, bcd0}, 32'h16);

        // Pause holds count and prescaler; reset overrides load and en.
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h37);
        tick();
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("t5_hold_bcd", {24'd0, bcd0}, 32'h37);
        end
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        tick();
        check_val("t5_ps_held", {31'd0, stp[0]}, 32'd0);
        tick();
        check_val("t5_resume_step", {31'd0, stp[0]}, 32'd1);
        check_val("t5_bcd38", {24'd0, bcd0}, 32'h38);
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h37);
        tick();
        set_in(0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h12);
        tick();
        check_val("t5_rst_bcd", {24'd0, bcd0}, 32'h00);
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        tick();
        tick();
        tick();
        check_val("t5_rst_ps", {31'd0, stp[0]}, 32'd1);

        // Modulus 24 with a step on every edge.
        set_in(1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h23);
        tick();
        set_in(1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00);
        tick();
        check_val("t6_m24_up", {24'd0, bcd1}, 32'h00);
        check_val("t6_m24_up_tc", {31'd0, tcs[1]}, 32'd1);
        set_in(1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00);
        tick();
        check_val("t6_m24_dn", {24'd0, bcd1}, 32'h23);
        check_val("t6_m24_dn_tc", {31'd0, tcs[1]}, 32'd1);

        // Three-digit ripple.
        set_in(2, 1'b0, 1'b1, 1'b1, 1'b1, 24'h999);
        tick();
        set_in(2, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000);
        tick();
        check_val("t6_m1000_wrap", {20'd0, bcd2}, 32'h000);
        check_val("t6_m1000_tc", {31'd0, tcs[2]}, 32'd1);
        set_in(2, 1'b0, 1'b1, 1'b1, 1'b1, 24'h099);
        tick();
        set_in(2, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000);
        tick();
        check_val("t6_m1000_carry", {20'd0, bcd2}, 32'h100);
        set_in(2, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000);
        tick();
        check_val("t6_m1000_borrow", {20'd0, bcd2}, 32'h099);

        // Randomized traffic on all three instances.
        repeat (4000) begin
            for (int k = 0; k < 3; k++) begin
                logic [23:0] v;
                logic [23:0] mask;
                mask = (24'd1 << (4 * nds[k])) - 24'd1;
                if ($urandom_range(0, 1) == 0)
                    v = to_bcd(int'($urandom_range(0, mods[k] - 1)));
                else
                    v = 24'($urandom) & mask;
                set_in(k, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                       1'($urandom), $urandom_range(0, 15) == 0, v);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
